// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: accepts a parallel pattern over valid/ready and shifts it
// out MSB-first one bit per clock, followed by an idle gap, with optional replay.
module serial_pattern_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned GAP_BITS = 2,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             load_data,
    input  logic [$clog2(WIDTH+1)-1:0]   load_len,
    input  logic                         repeat_en,
    input  logic                         abort,
    output logic                         x_out,
    output logic                         x_valid,
    output logic                         busy,
    output logic                         done
);
    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    cnt_q;
    logic [GW-1:0]    gap_q;
    logic             x_out_q;
    logic             x_valid_q;
    logic             done_q;

    logic [LW-1:0]    eff_len_d;
    logic [WIDTH-1:0] aligned_d;
    logic [WIDTH-1:0] start_pat_d;
    logic [LW-1:0]    start_len_d;
    logic             accept_d;
    logic             last_bit_d;
    logic             last_gap_d;
    logic             frame_end_d;
    logic             start_d;

    // Patterns are stored left-aligned so the next bit is always the MSB of the shifter.
    always_comb begin
        eff_len_d   = (load_len == '0 || load_len > LW'(WIDTH)) ? LW'(WIDTH) : load_len;
        aligned_d   = load_data << (LW'(WIDTH) - eff_len_d);
        start_pat_d = (state_q == S_IDLE) ? aligned_d : pat_q;
        start_len_d = (state_q == S_IDLE) ? eff_len_d : len_q;
        accept_d    = load_valid && load_ready && !abort;
        last_bit_d  = (state_q == S_SHIFT) && (cnt_q == '0);
        last_gap_d  = (state_q == S_GAP) && (gap_q == '0);
        frame_end_d = (GAP_BITS == 0) ? last_bit_d : last_gap_d;
        start_d     = (state_q == S_IDLE) ? accept_d : (!abort && frame_end_d && repeat_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (start_d) begin
            state_q   <= S_SHIFT;
            pat_q     <= start_pat_d;
            len_q     <= start_len_d;
            sh_q      <= start_pat_d << 1;
            cnt_q     <= start_len_d - LW'(1);
            x_out_q   <= start_pat_d[WIDTH-1];
            x_valid_q <= 1'b1;
            done_q    <= (start_len_d == LW'(1));
        end else if (state_q != S_IDLE && (abort || frame_end_d)) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (last_bit_d) begin
            state_q   <= S_GAP;
            gap_q     <= GW'(GAP_BITS - 1);
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            sh_q      <= sh_q << 1;
            cnt_q     <= cnt_q - LW'(1);
            x_out_q   <= sh_q[WIDTH-1];
            done_q    <= (cnt_q == LW'(1));
        end else if (state_q == S_GAP) begin
            gap_q     <= gap_q - GW'(1);
        end
    end

    assign load_ready = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q != S_IDLE);
    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: scoreboard of expected serial bits fed by a frame-level model,
// plus a GAP_BITS=0 instance for back-to-back replay.
module tb_serial_pattern_tx;
    localparam int unsigned GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid, load_ready, repeat_en, abort;
    logic [7:0] load_data;
    logic [3:0] load_len;
    logic       x_out, x_valid, busy, done;

    logic       b_load_valid, b_load_ready, b_repeat_en, b_abort;
    logic [7:0] b_load_data;
    logic [3:0] b_load_len;
    logic       b_x_out, b_x_valid, b_busy, b_done;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned idle    = 100;

    typedef struct packed {
        logic b;
        logic d;
        logic first;
        logic rep;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(8), .GAP_BITS(GAP), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .repeat_en(repeat_en), .abort(abort),
        .x_out(x_out), .x_valid(x_valid), .busy(busy), .done(done)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP_BITS(0), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_data(b_load_data), .load_len(b_load_len), .repeat_en(b_repeat_en), .abort(b_abort),
        .x_out(b_x_out), .x_valid(b_x_valid), .busy(b_busy), .done(b_done)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic int unsigned eff_len(input logic [3:0] len);
        return (len == 0 || len > 8) ? 8 : int'(len);
    endfunction

    // k frames of the same pattern; frames after the first are replays.
    function automatic void model_push(input logic [7:0] d, input logic [3:0] len, input int unsigned k);
        int unsigned l;
        exp_t e;
        l = eff_len(len);
        for (int unsigned f = 0; f < k; f++) begin
            for (int unsigned i = l; i > 0; i--) begin
                e.b     = d[i-1];
                e.d     = (i == 1);
                e.first = (i == l);
                e.rep   = (f > 0);
                exp_q.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (x_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 32'(x_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("x_out_bit", 32'(x_out), 32'(e.b));
                    chk("done_flag", 32'(done), 32'(e.d));
                    if (e.first && e.rep)  chk("repeat_gap", idle, GAP);
                    if (e.first && !e.rep) chk("fresh_gap_nonzero", 32'(idle >= 1), 32'd1);
                end
                idle = 0;
            end else begin
                chk("idle_x_out", 32'(x_out), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                idle++;
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic [3:0] len, input int unsigned k);
        int unsigned p, waited;
        p = eff_len(len) + GAP;
        @(negedge clk);
        load_data  = d;
        load_len   = len;
        load_valid = 1'b1;
        repeat_en  = (k > 1);
        #1;
        waited = 0;
        while (!load_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("handshake_ready", 32'(load_ready), 32'd1);
        if (!load_ready) begin
            load_valid = 1'b0;
            return;
        end
        model_push(d, len, k);
        @(posedge clk);
        for (int unsigned n = 1; n <= k * p + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom);
                load_len   = 4'($urandom);
            end
            if (n == (k - 1) * p + 1) repeat_en = 1'b0;
            chk("frame_busy", 32'(busy), 32'(n <= k * p));
            chk("frame_ready", 32'(load_ready), 32'(n > k * p));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bd;
        reset = 1'b1;
        load_valid = 1'b0; load_data = '0; load_len = '0; repeat_en = 1'b0; abort = 1'b0;
        b_load_valid = 1'b0; b_load_data = '0; b_load_len = '0; b_repeat_en = 1'b0; b_abort = 1'b0;
        #2;
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_x_valid", 32'(x_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready_low", 32'(load_ready), 32'd0);
        chk("rst_b_x_out", 32'(b_x_out), 32'd1);
        #10;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(load_ready), 32'd1);

        send_frame(8'hB2, 4'd8, 1);
        send_frame(8'hFD, 4'd3, 1);
        send_frame(8'hA5, 4'd0, 1);
        send_frame(8'hA5, 4'd15, 1);
        send_frame(8'h0C, 4'd4, 3);
        send_frame(8'h01, 4'd1, 2);

        // abort on the third bit of an 8-bit frame
        @(negedge clk);
        load_data = 8'hB2; load_len = 4'd8; load_valid = 1'b1;
        #1;
        chk("abort_hs_ready", 32'(load_ready), 32'd1);
        model_push(8'hB2, 4'd8, 1);
        repeat (5) void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk); load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_x_valid", 32'(x_valid), 32'd0);
        chk("abort_x_out", 32'(x_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(load_ready), 32'd1);

        // abort beats a load handshake in IDLE
        abort = 1'b1; load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd8;
        @(negedge clk);
        abort = 1'b0; load_valid = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_ready", 32'(load_ready), 32'd1);

        // asynchronous reset in the middle of a frame
        @(negedge clk);
        load_data = 8'hFF; load_len = 4'd8; load_valid = 1'b1;
        model_push(8'hFF, 4'd8, 1);
        @(posedge clk);
        @(negedge clk); load_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_x_valid", 32'(x_valid), 32'd0);
        chk("arst_x_out", 32'(x_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        exp_q.delete();
        #2 reset = 1'b0;
        @(negedge clk);
        chk("arst_release_ready", 32'(load_ready), 32'd1);

        // GAP_BITS=0 replay: no idle cycle between frames
        bd = 8'h05;
        b_load_data = bd; b_load_len = 4'd3; b_load_valid = 1'b1; b_repeat_en = 1'b1;
        #1;
        chk("b_hs_ready", 32'(b_load_ready), 32'd1);
        @(posedge clk);
        for (int unsigned s = 0; s < 9; s++) begin
            @(negedge clk);
            if (s == 0) b_load_valid = 1'b0;
            chk("b_x_valid", 32'(b_x_valid), 32'd1);
            chk("b_x_out", 32'(b_x_out), 32'(bd[2 - (s % 3)]));
            chk("b_done", 32'(b_done), 32'((s % 3) == 2));
            if (s == 6) b_repeat_en = 1'b0;
        end
        @(negedge clk);
        chk("b_end_x_valid", 32'(b_x_valid), 32'd0);
        chk("b_end_x_out", 32'(b_x_out), 32'd1);
        chk("b_end_ready", 32'(b_load_ready), 32'd1);

        for (int unsigned r = 0; r < 30; r++) begin
            send_frame(8'($urandom), 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
